sha256_msg_padder: RTL and testbench

//  Upstream feeder for the SHA-256 compression core.
//  - Reads NUM_OF_WORDS raw 32-bit message words from the shared single-port SRAM at message_addr.
//  - Appends FIPS 180-4 padding and emits the padded message as a valid/ready word stream, 16 words per 512-bit block.
//  - Carries block markers so the core can start a new block and re-seed its H registers.

---
 rtl/sha256_msg_padder.sv | 241 ++++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_padder
// Function : Reads a fixed-length message from single-port SRAM, appends
//            SHA-256 padding and streams it as 16-word blocks (valid/ready).
// Revision : 1.0  initial release
// ============================================================================
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [15:0] i_message_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_mem_clk,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  input  logic [31:0] i_mem_read_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_word,
  output logic [3:0]  o_out_widx,
  output logic        o_out_block_first,
  output logic        o_out_block_last,
  output logic        o_out_msg_last
);

  localparam int c_num_blocks = (NUM_OF_WORDS + 18) / 16;
  localparam int c_total      = 16 * c_num_blocks;
  localparam int c_gw         = $clog2(c_total) + 1;

  localparam logic [c_gw-1:0] c_n_g    = c_gw'(NUM_OF_WORDS);
  localparam logic [c_gw-1:0] c_last_g = c_gw'(c_total - 1);
  localparam logic [31:0]     c_len    = 32'(NUM_OF_WORDS * 32);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;

  logic [15:0]     r_base;
  logic [c_gw-1:0] r_g;
  logic [15:0]     r_mem_addr;

  // Stage 1: address presented to SRAM; stage 2: SRAM data valid.
  logic            r_s1_v;
  logic            r_s1_pad;
  logic [31:0]     r_s1_const;
  logic [c_gw-1:0] r_s1_g;
  logic            r_s2_v;
  logic            r_s2_pad;
  logic [31:0]     r_s2_const;
  logic [c_gw-1:0] r_s2_g;

  logic [31:0]     r_fq_word [2];
  logic [c_gw-1:0] r_fq_g    [2];
  logic            r_fq_wp;
  logic            r_fq_rp;
  logic [1:0]      r_fq_cnt;

  logic            r_out_v;
  logic [31:0]     r_out_word;
  logic [c_gw-1:0] r_out_g;

  logic            w_hs;
  logic [2:0]      w_total;
  logic            w_room;
  logic            w_issue;
  logic            w_is_idle;
  logic [c_gw-1:0] w_iss_g;
  logic            w_iss_pad;
  logic [31:0]     w_iss_const;
  logic [15:0]     w_iss_addr;
  logic            w_iss_last;
  logic [31:0]     w_cap_data;
  logic            w_load_out;
  logic            w_fq_pop;
  logic            w_cap_to_out;
  logic            w_fq_push;
  logic            w_drained;

  assign w_hs      = r_out_v & i_out_ready;
  assign w_is_idle = (r_state == c_st_idle);

  // Output register plus FIFO plus both pipeline stages share three slots of
  // credit; a handshake this cycle frees one, so issue can continue at full rate.
  assign w_total = {2'b00, r_out_v} + {2'b00, r_s1_v} + {2'b00, r_s2_v} + {1'b0, r_fq_cnt};
  assign w_room  = (w_total < 3'd3) | ((w_total == 3'd3) & w_hs);

  assign w_issue = (w_is_idle & i_start) | ((r_state == c_st_run) & w_room);
  assign w_iss_g = w_is_idle ? '0 : r_g;
  assign w_iss_pad  = (w_iss_g >= c_n_g);
  assign w_iss_last = (w_iss_g == c_last_g);
  assign w_iss_addr = w_is_idle ? i_message_addr
                                : (r_base + {{(16-c_gw){1'b0}}, w_iss_g});

  always_comb begin
    w_iss_const = 32'h0;
    if (w_iss_g == c_n_g) begin
      w_iss_const = 32'h8000_0000;
    end else if (w_iss_last) begin
      w_iss_const = c_len;
    end
  end

  assign w_cap_data   = r_s2_pad ? r_s2_const : i_mem_read_data;
  assign w_load_out   = ~r_out_v | w_hs;
  assign w_fq_pop     = w_load_out & (r_fq_cnt != 2'd0);
  assign w_cap_to_out = w_load_out & (r_fq_cnt == 2'd0) & r_s2_v;
  assign w_fq_push    = r_s2_v & ~w_cap_to_out;

  assign w_drained = ~r_s1_v & ~r_s2_v & (r_fq_cnt == 2'd0) & (~r_out_v | w_hs);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (i_start) w_state_nxt = c_st_run;
      c_st_run:   if (w_issue && w_iss_last) w_state_nxt = c_st_drain;
      c_st_drain: if (w_drained) w_state_nxt = c_st_done;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      c_st_run, c_st_drain: o_busy = 1'b1;
      c_st_done: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_base     <= 16'h0;
      r_g        <= '0;
      r_mem_addr <= 16'h0;
      r_s1_v     <= 1'b0;
      r_s1_pad   <= 1'b0;
      r_s1_const <= 32'h0;
      r_s1_g     <= '0;
      r_s2_v     <= 1'b0;
      r_s2_pad   <= 1'b0;
      r_s2_const <= 32'h0;
      r_s2_g     <= '0;
      r_fq_wp    <= 1'b0;
      r_fq_rp    <= 1'b0;
      r_fq_cnt   <= 2'd0;
      r_out_v    <= 1'b0;
      r_out_word <= 32'h0;
      r_out_g    <= '0;
    end else begin
      if (w_is_idle && i_start) begin
        r_base <= i_message_addr;
      end

      r_s1_v <= w_issue;
      if (w_issue) begin
        r_s1_pad   <= w_iss_pad;
        r_s1_const <= w_iss_const;
        r_s1_g     <= w_iss_g;
        r_g        <= w_iss_g + c_gw'(1);
        // Pad words never touch the SRAM, so the address walks only the message.
        if (!w_iss_pad) begin
          r_mem_addr <= w_iss_addr;
        end
      end

      r_s2_v     <= r_s1_v;
      r_s2_pad   <= r_s1_pad;
      r_s2_const <= r_s1_const;
      r_s2_g     <= r_s1_g;

      if (w_fq_push) begin
        r_fq_wp <= ~r_fq_wp;
      end
      if (w_fq_pop) begin
        r_fq_rp <= ~r_fq_rp;
      end
      case ({w_fq_push, w_fq_pop})
        2'b10:   r_fq_cnt <= r_fq_cnt + 2'd1;
        2'b01:   r_fq_cnt <= r_fq_cnt - 2'd1;
        default: r_fq_cnt <= r_fq_cnt;
      endcase

      if (w_load_out) begin
        if (r_fq_cnt != 2'd0) begin
          r_out_v    <= 1'b1;
          r_out_word <= r_fq_word[r_fq_rp];
          r_out_g    <= r_fq_g[r_fq_rp];
        end else if (r_s2_v) begin
          r_out_v    <= 1'b1;
          r_out_word <= w_cap_data;
          r_out_g    <= r_s2_g;
        end else begin
          r_out_v    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fq_push) begin
      r_fq_word[r_fq_wp] <= w_cap_data;
      r_fq_g[r_fq_wp]    <= r_s2_g;
    end
  end

  // ----------------------------------------------------------- outputs
  assign o_mem_clk         = clk;
  assign o_mem_we          = 1'b0;
  assign o_mem_addr        = r_mem_addr;
  assign o_out_valid       = r_out_v;
  assign o_out_word        = r_out_word;
  assign o_out_widx        = r_out_g[3:0];
  assign o_out_block_first = r_out_v & (r_out_g[3:0] == 4'd0);
  assign o_out_block_last  = r_out_v & (r_out_g[3:0] == 4'd15);
  assign o_out_msg_last    = r_out_v & (r_out_g == c_last_g);

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_padder
// Function : Directed self-checking bench for sha256_msg_padder (N=20/13/14).
// Revision : 1.0  initial release
// ============================================================================
module tb_sha256_msg_padder;

  logic        clk;
  logic        reset_n;
  logic        st    [3];
  logic        rdy   [3];
  logic [15:0] ma    [3];
  logic [15:0] maddr [3];
  logic [31:0] rdat  [3];
  logic [31:0] ow    [3];
  logic [3:0]  wi    [3];
  logic        busy  [3];
  logic        done  [3];
  logic        mclk  [3];
  logic        mwe   [3];
  logic        ov    [3];
  logic        bf    [3];
  logic        bl    [3];
  logic        ml    [3];

  logic [31:0] sram [0:65535];
  logic [31:0] cap_w [64];
  logic [6:0]  cap_f [64];
  int          n_cmp;
  int          n_mis;
  int          nh;
  logic        seen_ffff;
  logic        seen_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sha256_msg_padder #(
      .NUM_OF_WORDS(gi == 0 ? 20 : (gi == 1 ? 13 : 14))
    ) u_dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .i_start           (st[gi]),
      .i_message_addr    (ma[gi]),
      .o_busy            (busy[gi]),
      .o_done            (done[gi]),
      .o_mem_clk         (mclk[gi]),
      .o_mem_we          (mwe[gi]),
      .o_mem_addr        (maddr[gi]),
      .i_mem_read_data   (rdat[gi]),
      .o_out_valid       (ov[gi]),
      .i_out_ready       (rdy[gi]),
      .o_out_word        (ow[gi]),
      .o_out_widx        (wi[gi]),
      .o_out_block_first (bf[gi]),
      .o_out_block_last  (bl[gi]),
      .o_out_msg_last    (ml[gi])
    );
  end

  // Synchronous SRAM: data for the address sampled at an edge is valid after it.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdat[i] <= sram[maddr[i]];
  end

  function automatic int nw(input int s);
    return (s == 0) ? 20 : ((s == 1) ? 13 : 14);
  endfunction

  function automatic logic [31:0] msgw(input int k);
    logic [31:0] w;
    w = 32'h0123_4567;
    for (int j = 0; j < k; j++) w = {w[30:0], w[31]};
    return (k == 19) ? 32'h0 : w;
  endfunction

  function automatic logic [31:0] expw(input int k, input int n, input int t);
    if (k < n)      return msgw(k);
    if (k == n)     return 32'h8000_0000;
    if (k == t - 1) return n * 32;
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One message on DUT `sel`; hold = cycles start stays high, rp = mid-run
  // start pulse cycle (0 = none), rst_at = reset after this many handshakes.
  task automatic run(input int sel, input logic [15:0] base, input bit rnd,
                     input int hold, input int rp, input int rst_at);
    int n, t, firstv, lasths, donec, nd, busy_bad, stall_bad, we_bad, addr_bad, maxoff;
    logic        prev_stall;
    logic [31:0] prev_w;
    logic [3:0]  prev_i;
    logic [15:0] off;
    n = nw(sel);
    t = 16 * ((n + 18) / 16);
    for (int k = 0; k < n; k++) begin
      off = base + 16'(k);
      sram[off] = msgw(k);
    end
    nh = 0; firstv = -1; lasths = -1; donec = -1; nd = 0;
    busy_bad = 0; stall_bad = 0; we_bad = 0; addr_bad = 0; maxoff = 0;
    prev_stall = 1'b0; prev_w = 32'h0; prev_i = 4'h0;
    seen_ffff = 1'b0; seen_0000 = 1'b0;
    @(negedge clk);
    st[sel] = 1'b1;
    ma[sel] = base;
    rdy[sel] = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (rst_at > 0 && nh == rst_at) begin
        reset_n  = 1'b0;
        st[sel]  = 1'b0;
        rdy[sel] = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", ov[sel], 0);
        chk("rst_mid_busy", busy[sel], 0);
        chk("rst_mid_done", done[sel], 0);
        chk("rst_mid_maddr", maddr[sel], 16'h0);
        reset_n = 1'b1;
        return;
      end
      if (c == hold) st[sel] = 1'b0;
      if (rp > 0 && c == rp) st[sel] = 1'b1;
      if (rp > 0 && c == rp + 1) st[sel] = 1'b0;
      if (donec >= 0) begin
        chk("busy_after_done", busy[sel], 0);
        chk("done_width", done[sel], 0);
        break;
      end
      if (mwe[sel]) we_bad++;
      if (!busy[sel]) busy_bad++;
      off = maddr[sel] - base;
      if (int'(off) >= n) addr_bad++;
      if (int'(off) > maxoff) maxoff = int'(off);
      if (maddr[sel] == 16'hFFFF) seen_ffff = 1'b1;
      if (maddr[sel] == 16'h0000) seen_0000 = 1'b1;
      if (prev_stall && (ov[sel] !== 1'b1 || ow[sel] !== prev_w || wi[sel] !== prev_i))
        stall_bad++;
      if (ov[sel] && firstv < 0) firstv = c;
      if (done[sel]) begin
        nd++;
        donec = c;
      end
      rdy[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = ov[sel] & ~rdy[sel];
      prev_w = ow[sel];
      prev_i = wi[sel];
      if (ov[sel] && rdy[sel]) begin
        if (nh < 64) begin
          cap_w[nh] = ow[sel];
          cap_f[nh] = {wi[sel], bf[sel], bl[sel], ml[sel]};
        end
        nh++;
        lasths = c;
      end
    end
    st[sel] = 1'b0;
    rdy[sel] = 1'b0;
    if (rst_at > 0) begin
      chk("rst_point_reached", nh, rst_at);
      return;
    end
    chk("hs_count", nh, t);
    chk("first_valid_cycle", firstv, 3);
    chk("done_count", nd, 1);
    chk("done_latency", donec, lasths + 1);
    chk("busy_gaps", busy_bad, 0);
    chk("stall_changes", stall_bad, 0);
    chk("mem_we_high", we_bad, 0);
    chk("addr_out_of_range", addr_bad, 0);
    chk("addr_max_offset", maxoff, n - 1);
    if (!rnd) chk("contiguous_span", lasths - firstv, t - 1);
    for (int k = 0; k < t && k < 64; k++) begin
      chk($sformatf("word%0d", k), cap_w[k], expw(k, n, t));
      chk($sformatf("flags%0d", k), cap_f[k],
          {k[3:0], (k % 16) == 0, (k % 16) == 15, k == t - 1});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; rdy[i] = 1'b0; ma[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    chk("reset_valid", ov[0], 0);
    chk("reset_busy", busy[0], 0);
    chk("reset_done", done[0], 0);
    chk("reset_maddr", maddr[0], 16'h0);
    chk("reset_word", ow[0], 32'h0);
    chk("reset_flags", {wi[0], bf[0], bl[0], ml[0]}, 7'h0);
    chk("reset_we", mwe[0], 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full-rate N=20 message with hand-computed spot values
    run(0, 16'h0000, 1'b0, 1, 0, 0);
    chk("n20_w0", cap_w[0], 32'h0123_4567);
    chk("n20_w1", cap_w[1], 32'h0246_8ACE);
    chk("n20_w19", cap_w[19], 32'h0);
    chk("n20_w20", cap_w[20], 32'h8000_0000);
    chk("n20_w30", cap_w[30], 32'h0);
    chk("n20_w31", cap_w[31], 32'h0000_0280);
    chk("n20_blast15", cap_f[15], {4'd15, 1'b0, 1'b1, 1'b0});
    chk("n20_blast31", cap_f[31], {4'd15, 1'b0, 1'b1, 1'b1});

    // Random back-pressure
    run(0, 16'h0000, 1'b1, 1, 0, 0);

    // Single-block and two-block boundaries
    run(1, 16'h0200, 1'b0, 1, 0, 0);
    chk("n13_w13", cap_w[13], 32'h8000_0000);
    chk("n13_w14", cap_w[14], 32'h0);
    chk("n13_w15", cap_w[15], 32'h0000_01A0);
    chk("n13_msglast", cap_f[15], {4'd15, 1'b0, 1'b1, 1'b1});
    run(2, 16'h0300, 1'b0, 1, 0, 0);
    chk("n14_w14", cap_w[14], 32'h8000_0000);
    chk("n14_w15", cap_w[15], 32'h0);
    chk("n14_w30", cap_w[30], 32'h0);
    chk("n14_w31", cap_w[31], 32'h0000_01C0);

    // Start held two cycles, then re-pulsed mid-run
    run(0, 16'h0000, 1'b0, 2, 10, 0);

    // Reset after handshake of w9, then a fresh full message
    run(0, 16'h0000, 1'b0, 1, 0, 10);
    run(0, 16'h0000, 1'b0, 1, 0, 0);

    // Address offset and 16-bit wrap
    run(0, 16'h0100, 1'b0, 1, 0, 0);
    run(0, 16'hFFF8, 1'b0, 1, 0, 0);
    chk("wrap_saw_ffff", seen_ffff, 1);
    chk("wrap_saw_0000", seen_0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
